// File: rtl/spi_slave_responder.sv
// SPI slave responder: single- or quad-lane SPI slave with word-level
// tx/rx handshakes. All SPI inputs are resynchronised into pclk and the
// SPI clock edges are recovered from the synchronised sclk.
module spi_slave_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic [3:0]            mosi,
  output logic [3:0]            miso,
  output logic [3:0]            miso_oe,
  input  logic                  quad_en,
  input  logic                  quad_tx,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0]      sclk_sync, cs_sync;
  logic [SYNC_STAGES-1:0][3:0] mosi_sync;
  logic                        sclk_s, cs_s, sclk_prev, cs_prev;
  logic [3:0]                  mosi_s;

  logic rise, fall, lead, trail, sample_edge, drive_edge, cs_fall;
  logic start, stop, act_sample, act_drive, word_done, load;
  logic q_quad, q_qtx, rx_en, tx_en, skip;

  logic [CW-1:0]         cnt, cnt_last;
  logic [DATA_WIDTH-1:0] rx_sr, rx_next, tx_sr, tx_shifted;
  logic [3:0]            miso_q, tx_bits;

  // Input synchronisers; idle levels held in reset so no false edges appear
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= CPOL;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];

  assign rise        = !sclk_prev && sclk_s;
  assign fall        = sclk_prev && !sclk_s;
  assign lead        = CPOL ? fall : rise;
  assign trail       = CPOL ? rise : fall;
  assign sample_edge = CPHA ? trail : lead;
  assign drive_edge  = CPHA ? lead : trail;
  assign cs_fall     = cs_prev && !cs_s;

  // Transfer state register
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_n;
  end

  // Next state: cs_n alone frames the transfer, sclk never moves the FSM
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cs_fall) state_n = ACTIVE;
      ACTIVE:  if (cs_s)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign start      = (state == IDLE) && cs_fall;
  assign stop       = (state == ACTIVE) && cs_s;
  assign act_sample = (state == ACTIVE) && !cs_s && sample_edge;
  assign act_drive  = (state == ACTIVE) && !cs_s && drive_edge;
  assign rx_en      = !(q_quad && q_qtx);
  assign tx_en      = !q_quad || q_qtx;
  assign cnt_last   = q_quad ? CW'(DATA_WIDTH / 4 - 1) : CW'(DATA_WIDTH - 1);
  assign word_done  = act_sample && (cnt == cnt_last);
  // The first load uses the live mode inputs since the latch updates on the same edge
  assign load       = (start && (!quad_en || quad_tx)) || (word_done && tx_en);

  assign rx_next    = q_quad ? {rx_sr[DATA_WIDTH-5:0], mosi_s}
                             : {rx_sr[DATA_WIDTH-2:0], mosi_s[0]};
  assign tx_shifted = q_quad ? {tx_sr[DATA_WIDTH-5:0], 4'b0000}
                             : {tx_sr[DATA_WIDTH-2:0], 1'b0};

  // Shift registers, word counter and the tx/rx handshakes
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      q_quad      <= 1'b0;
      q_qtx       <= 1'b0;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      miso_q      <= '0;
      skip        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      if (start) begin
        q_quad <= quad_en;
        q_qtx  <= quad_tx;
      end

      // Partial words are thrown away whenever a transfer opens or closes
      if (start || stop) begin
        cnt   <= '0;
        rx_sr <= '0;
      end else if (act_sample) begin
        cnt   <= word_done ? '0 : cnt + CW'(1);
        rx_sr <= rx_next;
      end

      if (start || stop) begin
        miso_q <= '0;
        skip   <= 1'b0;
      end

      // With CPHA=0 a word-completion reload already presents its MSB, so
      // the drive edge right after it must not shift
      if (load) begin
        tx_sr       <= tx_valid ? tx_data : '0;
        tx_ready    <= tx_valid;
        tx_underrun <= !tx_valid;
        skip        <= word_done;
      end else if (act_drive) begin
        if (!CPHA && skip) begin
          skip <= 1'b0;
        end else begin
          miso_q <= q_quad ? tx_sr[DATA_WIDTH-1 -: 4] : {3'b000, tx_sr[DATA_WIDTH-1]};
          tx_sr  <= tx_shifted;
        end
      end

      if (word_done && rx_en) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Output lanes: CPHA=1 shows bits only after a drive edge, CPHA=0 straight from the shifter
  always_comb begin
    busy    = (state == ACTIVE);
    miso_oe = 4'b0000;
    if (state == ACTIVE) begin
      if (!q_quad)    miso_oe = 4'b0001;
      else if (q_qtx) miso_oe = 4'b1111;
      else            miso_oe = 4'b0000;
    end
    if (CPHA)        tx_bits = miso_q;
    else if (q_quad) tx_bits = tx_sr[DATA_WIDTH-1 -: 4];
    else             tx_bits = {3'b000, tx_sr[DATA_WIDTH-1]};
    miso = tx_bits & miso_oe;
  end

endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, named pclk and areset.
REQ-002 Parameter DATA_WIDTH, 32, word length in bits; multiple of 4.
REQ-003 Parameter CPOL, 0, sclk idle level.
REQ-004 Parameter CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Parameter SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi.
REQ-006 Ports SHALL be:
- pclk  in  1  system clock
- areset  in  1  async reset, active-low
- sclk  in  1  SPI clock from master
- cs_n  in  1  chip select for this slave, active-low
- mosi  in  4  master-out lines mosi0..mosi3 (bit n = mosin)
- miso  out  4  slave-out lines miso0..miso3
- miso_oe  out  4  per-line output enable
- quad_en  in  1  0 = standard single-lane, 1 = quad
- quad_tx  in  1  quad only: 1 = slave transmits, 0 = slave receives
- tx_data  in  DATA_WIDTH  next word to transmit
- tx_valid  in  1  tx_data available
- tx_ready  out  1  one-cycle pulse: tx_data consumed
- tx_underrun  out  1  one-cycle pulse: load point with tx_valid low
- rx_data  out  DATA_WIDTH  last received word
- rx_valid  out  1  held high until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- rx_overrun  out  1  one-cycle pulse: word dropped
- busy  out  1  high while in ACTIVE

Function
REQ-007 sclk, cs_n, mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronized sclk; sclk frequency SHALL be at most pclk/4.
REQ-008 Leading edge = rising if CPOL=0, falling if CPOL=1; sample edge = leading if CPHA=0, else trailing; drive edge = the other one.
REQ-009 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on synchronized cs_n falling; ACTIVE->IDLE on synchronized cs_n rising, from any bit position.
REQ-010 quad_en and quad_tx SHALL be latched on IDLE->ACTIVE and held for the whole transfer.
REQ-011 Bits per sample edge: 1 in standard mode (mosi[0]), 4 in quad mode (mosi[3] = MSB of nibble); words are MSB/nibble-first.
REQ-012 Edge counter SHALL count to DATA_WIDTH (standard) or DATA_WIDTH/4 (quad) sample edges, then wrap to 0 and continue while cs_n low.
REQ-013 Receive is disabled in quad mode with quad_tx=1.
REQ-014 On word completion with receive enabled: if rx_valid is low or rx_ready is high in that cycle, rx_data SHALL update and rx_valid SHALL be high the next cycle; otherwise rx_data SHALL be kept and rx_overrun SHALL pulse.
REQ-015 rx_valid SHALL clear the cycle after rx_valid && rx_ready unless a new word lands simultaneously.
REQ-016 Load points are IDLE->ACTIVE and each word completion. At a load point, tx_valid=1 SHALL load tx_data and pulse tx_ready; tx_valid=0 SHALL load all-zero and pulse tx_underrun.
REQ-017 Transmit is disabled in quad mode with quad_tx=0; no loads and no tx pulses occur then.
REQ-018 miso_oe SHALL be 4'b0001 for standard, 4'b1111 for quad transmit, 4'b0000 for quad receive; 4'b0000 in IDLE.
REQ-019 Standard mode SHALL drive miso[0] from the shift-register MSB; quad mode SHALL drive miso[3:0] from the top nibble; unused or disabled lines SHALL be 0.
REQ-020 CPHA=0: the first bit SHALL appear within 1 pclk of the load; it SHALL advance on each drive edge except the drive edge following a word-completion reload.
REQ-021 CPHA=1: every bit, including the first, SHALL advance on a drive edge.
REQ-022 cs_n rise mid-word SHALL discard partial rx bits, clear the counter, set miso_oe=0, and produce no rx_valid; an already-consumed tx word is not re-offered.
REQ-023 busy SHALL be 1 exactly in ACTIVE.

Reset
REQ-024 On areset low, all outputs SHALL be 0 immediately and the FSM SHALL be IDLE.
REQ-025 During reset, cs_n synchronizers SHALL hold 1 and sclk synchronizers SHALL hold CPOL.
REQ-026 Reset mid-transfer SHALL abort the transfer; after release, the next cs_n fall SHALL start a fresh word.

Verification
REQ-027 Standard, CPOL=0/CPHA=0, tx_data=0xA5A5_0F0F, master sends 0x1234_5678 -> rx_data=0x1234_5678, one rx_valid, miso bitstream 0xA5A5_0F0F, one tx_ready.
REQ-028 Quad receive, master sends 0xDEAD_BEEF in 8 nibbles -> rx_data=0xDEAD_BEEF, miso_oe=0000, no tx_ready/tx_underrun.
REQ-029 Quad transmit, CPHA=1, tx_data=0xCAFE_F00D -> master captures 0xCAFE_F00D, miso_oe=1111, no rx_valid.
REQ-030 Two back-to-back words, rx_ready tied 0 -> first word kept in rx_data, rx_overrun pulses once; tx_valid low at second load -> tx_underrun pulses and the second miso word is 0.
REQ-031 cs_n rises after 13 bits -> no rx_valid, busy falls, miso_oe=0; the next full transfer receives correctly.
REQ-032 All four CPOL/CPHA combinations, standard mode, 0x8000_0001 both directions -> exact match.
